// File: rtl/bridge_target_adapter.sv
// bridge_target_adapter: forwards arbitration-tree requests to a single target,
// tracks up to MAX_OUT outstanding transactions in an in-order FIFO of
// {ID, tag, aux}, and routes each in-order target response back to the
// initiator whose one-hot ID was stored when the request was granted.
module bridge_target_adapter #(
  parameter  int unsigned ID_WIDTH   = 17,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned BYTE_NUM   = DATA_WIDTH / 8,
  parameter  int unsigned TAG_WIDTH  = BYTE_NUM,
  parameter  int unsigned AUX_WIDTH  = 8,
  parameter  int unsigned MAX_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // request side, from the arbitration tree
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BYTE_NUM-1:0]   data_be_i,
  input  logic [TAG_WIDTH-1:0]  data_tag_i,
  input  logic [AUX_WIDTH-1:0]  data_aux_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  // target request channel
  output logic                  tgt_req_o,
  output logic [ADDR_WIDTH-1:0] tgt_add_o,
  output logic                  tgt_wen_o,
  output logic [DATA_WIDTH-1:0] tgt_wdata_o,
  output logic [BYTE_NUM-1:0]   tgt_be_o,
  input  logic                  tgt_gnt_i,
  // target response channel
  input  logic                  tgt_r_valid_i,
  input  logic [DATA_WIDTH-1:0] tgt_r_rdata_i,
  input  logic                  tgt_r_opc_i,
  // response side, back to the initiators
  output logic [ID_WIDTH-1:0]   data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]  data_r_rtag_o,
  output logic                  data_r_opc_o,
  output logic [AUX_WIDTH-1:0]  data_r_aux_o,
  // status
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  // Outstanding-transaction bookkeeping
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;

  // FIFO storage, no reset needed: entries are only read after being written
  logic [ID_WIDTH-1:0]  id_mem_q  [MAX_OUT];
  logic [TAG_WIDTH-1:0] tag_mem_q [MAX_OUT];
  logic [AUX_WIDTH-1:0] aux_mem_q [MAX_OUT];

  // Registered response path
  logic [ID_WIDTH-1:0]   r_valid_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic [TAG_WIDTH-1:0]  r_tag_q;
  logic                  r_opc_q;
  logic [AUX_WIDTH-1:0]  r_aux_q;
  logic                  err_q;

  // Full/empty flags and the combinational request/grant path
  always_comb begin
    full       = (count_q == CNT_W'(MAX_OUT));
    empty      = (count_q == '0);
    tgt_req_o  = data_req_i & ~full;
    data_gnt_o = data_req_i & tgt_gnt_i & ~full;
    push       = data_gnt_o;
    pop        = tgt_r_valid_i & ~empty;
  end

  // Request payload passes straight through to the target
  always_comb begin
    tgt_add_o   = data_add_i;
    tgt_wen_o   = data_wen_i;
    tgt_wdata_o = data_wdata_i;
    tgt_be_o    = data_be_i;
  end

  // Next occupancy: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally since MAX_OUT is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Store {ID, tag, aux} of each granted request at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem_q[wr_ptr_q]  <= data_ID_i;
      tag_mem_q[wr_ptr_q] <= data_tag_i;
      aux_mem_q[wr_ptr_q] <= data_aux_i;
    end
  end

  // Register the response one cycle after the target reports it; flag strays
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_q <= '0;
      r_rdata_q <= '0;
      r_tag_q   <= '0;
      r_opc_q   <= 1'b0;
      r_aux_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      r_valid_q <= pop ? id_mem_q[rd_ptr_q] : '0;
      if (pop) begin
        r_rdata_q <= tgt_r_rdata_i;
        r_tag_q   <= tag_mem_q[rd_ptr_q];
        r_opc_q   <= tgt_r_opc_i;
        r_aux_q   <= aux_mem_q[rd_ptr_q];
      end
      if (tgt_r_valid_i && empty) err_q <= 1'b1;
    end
  end

  // Output mapping
  always_comb begin
    data_r_valid_o = r_valid_q;
    data_r_rdata_o = r_rdata_q;
    data_r_rtag_o  = r_tag_q;
    data_r_opc_o   = r_opc_q;
    data_r_aux_o   = r_aux_q;
    busy_o         = ~empty;
    err_o          = err_q;
  end

endmodule

// File: tb/tb_bridge_target_adapter.sv
// Testbench for bridge_target_adapter: a transaction model predicts grants and
// queues expected responses; a negedge monitor pops and compares them.
module tb_bridge_target_adapter;

  localparam int unsigned ID_W    = 17;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned TAG_W   = BE_W;
  localparam int unsigned AUX_W   = 8;
  localparam int unsigned MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              data_req_i = 1'b0;
  logic [ADDR_W-1:0] data_add_i = '0;
  logic              data_wen_i = 1'b1;
  logic [DATA_W-1:0] data_wdata_i = '0;
  logic [BE_W-1:0]   data_be_i = '0;
  logic [TAG_W-1:0]  data_tag_i = '0;
  logic [AUX_W-1:0]  data_aux_i = '0;
  logic [ID_W-1:0]   data_ID_i = '0;
  logic              data_gnt_o;
  logic              tgt_req_o;
  logic [ADDR_W-1:0] tgt_add_o;
  logic              tgt_wen_o;
  logic [DATA_W-1:0] tgt_wdata_o;
  logic [BE_W-1:0]   tgt_be_o;
  logic              tgt_gnt_i = 1'b1;
  logic              tgt_r_valid_i = 1'b0;
  logic [DATA_W-1:0] tgt_r_rdata_i = '0;
  logic              tgt_r_opc_i = 1'b0;
  logic [ID_W-1:0]   data_r_valid_o;
  logic [DATA_W-1:0] data_r_rdata_o;
  logic [TAG_W-1:0]  data_r_rtag_o;
  logic              data_r_opc_o;
  logic [AUX_W-1:0]  data_r_aux_o;
  logic              busy_o;
  logic              err_o;

  bridge_target_adapter #(
    .ID_WIDTH  (ID_W),
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W),
    .TAG_WIDTH (TAG_W),
    .AUX_WIDTH (AUX_W),
    .MAX_OUT   (MAX_OUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_req_i    (data_req_i),
    .data_add_i    (data_add_i),
    .data_wen_i    (data_wen_i),
    .data_wdata_i  (data_wdata_i),
    .data_be_i     (data_be_i),
    .data_tag_i    (data_tag_i),
    .data_aux_i    (data_aux_i),
    .data_ID_i     (data_ID_i),
    .data_gnt_o    (data_gnt_o),
    .tgt_req_o     (tgt_req_o),
    .tgt_add_o     (tgt_add_o),
    .tgt_wen_o     (tgt_wen_o),
    .tgt_wdata_o   (tgt_wdata_o),
    .tgt_be_o      (tgt_be_o),
    .tgt_gnt_i     (tgt_gnt_i),
    .tgt_r_valid_i (tgt_r_valid_i),
    .tgt_r_rdata_i (tgt_r_rdata_i),
    .tgt_r_opc_i   (tgt_r_opc_i),
    .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o),
    .data_r_rtag_o (data_r_rtag_o),
    .data_r_opc_o  (data_r_opc_o),
    .data_r_aux_o  (data_r_aux_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
    logic [AUX_W-1:0] aux;
  } req_t;

  typedef struct {
    req_t              r;
    logic [DATA_W-1:0] rdata;
    logic              opc;
  } resp_t;

  req_t  req_q  [$];
  resp_t resp_q [$];

  int errors = 0;
  int checks = 0;

  // model state and per-cycle expectations
  int   m_count = 0;
  logic m_err   = 1'b0;
  logic e_gnt, e_treq, e_busy, e_err;
  logic mon_en = 1'b0;

  logic [ID_W-1:0]   last_id    = '0;
  logic [DATA_W-1:0] last_rdata = '0;
  logic [TAG_W-1:0]  last_tag   = '0;
  logic              last_opc   = 1'b0;
  logic [AUX_W-1:0]  last_aux   = '0;

  // Scoreboard monitor: compares the registered response outputs each cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_q.size() > 0) begin
        resp_t r;
        r = resp_q.pop_front();
        last_id    = r.r.id;
        last_rdata = r.rdata;
        last_tag   = r.r.tag;
        last_opc   = r.opc;
        last_aux   = r.r.aux;
      end else begin
        last_id = '0;
      end
      checks++;
      if (data_r_valid_o !== last_id) begin
        errors++;
        $display("FAIL resp_valid t=%0t got=%h exp=%h", $time, data_r_valid_o, last_id);
      end
      checks++;
      if (data_r_rdata_o !== last_rdata) begin
        errors++;
        $display("FAIL resp_rdata t=%0t got=%h exp=%h", $time, data_r_rdata_o, last_rdata);
      end
      checks++;
      if (data_r_rtag_o !== last_tag) begin
        errors++;
        $display("FAIL resp_tag t=%0t got=%h exp=%h", $time, data_r_rtag_o, last_tag);
      end
      checks++;
      if (data_r_opc_o !== last_opc) begin
        errors++;
        $display("FAIL resp_opc t=%0t got=%b exp=%b", $time, data_r_opc_o, last_opc);
      end
      checks++;
      if (data_r_aux_o !== last_aux) begin
        errors++;
        $display("FAIL resp_aux t=%0t got=%h exp=%h", $time, data_r_aux_o, last_aux);
      end
    end
  end

  // One bus cycle: drive inputs after the edge, then predict and update model
  task automatic step(input logic req, input logic [ID_W-1:0] id,
                      input logic [TAG_W-1:0] tag, input logic [AUX_W-1:0] aux,
                      input logic rv, input logic [DATA_W-1:0] rdata, input logic opc);
    @(posedge clk);
    #1;
    data_req_i    = req;
    data_ID_i     = id;
    data_tag_i    = tag;
    data_aux_i    = aux;
    data_add_i    = $urandom;
    data_wdata_i  = $urandom;
    data_be_i     = BE_W'($urandom);
    data_wen_i    = 1'($urandom);
    tgt_r_valid_i = rv;
    tgt_r_rdata_i = rdata;
    tgt_r_opc_i   = opc;
    @(negedge clk);
    #1;
    e_treq = req && (m_count != MAX_OUT);
    e_gnt  = e_treq && tgt_gnt_i;
    e_busy = (m_count != 0);
    e_err  = m_err;
    if (rv) begin
      if (m_count > 0) begin
        req_t e;
        e = req_q.pop_front();
        resp_q.push_back('{e, rdata, opc});
        m_count--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (e_gnt) begin
      req_q.push_back('{id, tag, aux});
      m_count++;
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({data_r_valid_o, data_r_rdata_o, data_r_rtag_o, data_r_opc_o, data_r_aux_o} !== '0) begin
      errors++;
      $display("FAIL reset_resp got=%h/%h/%h/%b/%h exp=0", data_r_valid_o, data_r_rdata_o,
               data_r_rtag_o, data_r_opc_o, data_r_aux_o);
    end
    checks++;
    if ({busy_o, err_o, tgt_req_o, data_gnt_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status got=%b%b%b%b exp=0000", busy_o, err_o, tgt_req_o, data_gnt_o);
    end
    @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    step(1'b1, 17'h00004, 4'h5, 8'hA3, 1'b0, '0, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b1 || tgt_req_o !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt got=%b/%b exp=1/1", data_gnt_o, tgt_req_o);
    end
    checks++;
    if ({tgt_add_o, tgt_wen_o, tgt_wdata_o, tgt_be_o} !==
        {data_add_i, data_wen_i, data_wdata_i, data_be_i}) begin
      errors++;
      $display("FAIL passthru got=%h/%b/%h/%h exp=%h/%b/%h/%h", tgt_add_o, tgt_wen_o,
               tgt_wdata_o, tgt_be_o, data_add_i, data_wen_i, data_wdata_i, data_be_i);
    end
    idle();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got=%b exp=1", busy_o);
    end
    idle();
    step(1'b0, '0, '0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
    idle();
    checks++;
    if (data_r_valid_o !== 17'h00004 || data_r_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_resp got=%h/%h exp=00004/deadbeef", data_r_valid_o, data_r_rdata_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got=%b exp=0", busy_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ID_W'(1) << i, TAG_W'(i), AUX_W'(8'h10 + i), 1'b0, '0, 1'b0);
      checks++;
      if (data_gnt_o !== e_gnt || e_gnt !== 1'b1) begin
        errors++;
        $display("FAIL fill_gnt%0d got=%b exp=1", i, data_gnt_o);
      end
    end
    step(1'b1, 17'h00010, 4'h4, 8'h14, 1'b0, '0, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b0 || tgt_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL full_block got=%b/%b/%b exp=0/0/1", data_gnt_o, tgt_req_o, busy_o);
    end
    step(1'b1, 17'h00010, 4'h4, 8'h14, 1'b1, 32'h0BAD_F00D, 1'b1);
    checks++;
    if (data_gnt_o !== 1'b0 || tgt_req_o !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_gnt got=%b/%b exp=0/0", data_gnt_o, tgt_req_o);
    end
    step(1'b1, 17'h00010, 4'h4, 8'h14, 1'b0, '0, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b1 || e_gnt !== 1'b1) begin
      errors++;
      $display("FAIL after_pop_gnt got=%b exp=1", data_gnt_o);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, DATA_W'($urandom), 1'($urandom));
    idle();
    checks++;
    if (busy_o !== e_busy || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_drain got=%b exp=0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   dut_grants = 0;
    logic g1 = 1'b0, g2 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step(sent < 10, ID_W'(1) << (sent % ID_W), TAG_W'(sent), AUX_W'(8'h30 + sent),
           g2, DATA_W'($urandom), 1'($urandom));
      checks++;
      if (data_gnt_o !== e_gnt || tgt_req_o !== e_treq) begin
        errors++;
        $display("FAIL b2b_gnt c=%0d got=%b/%b exp=%b/%b", c, data_gnt_o, tgt_req_o, e_gnt, e_treq);
      end
      checks++;
      if (tgt_add_o !== data_add_i || tgt_wdata_o !== data_wdata_i) begin
        errors++;
        $display("FAIL b2b_passthru c=%0d got=%h/%h exp=%h/%h", c, tgt_add_o, tgt_wdata_o,
                 data_add_i, data_wdata_i);
      end
      if (data_gnt_o === 1'b1) dut_grants++;
      if (e_gnt) sent++;
      g2 = g1;
      g1 = e_gnt;
    end
    checks++;
    if (dut_grants !== 10 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_total got=%0d busy=%b exp=10 busy=0", dut_grants, busy_o);
    end
  endtask

  task automatic test_simul_push_pop();
    step(1'b1, 17'h00100, 4'h8, 8'h51, 1'b0, '0, 1'b0);
    step(1'b1, 17'h00200, 4'h9, 8'h52, 1'b0, '0, 1'b0);
    step(1'b1, 17'h00400, 4'hA, 8'h53, 1'b1, 32'h1234_5678, 1'b0);
    checks++;
    if (data_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_gnt got=%b exp=1", data_gnt_o);
    end
    idle();
    checks++;
    if (data_r_valid_o !== 17'h00100 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_resp got=%h busy=%b exp=00100 busy=1", data_r_valid_o, busy_o);
    end
    step(1'b0, '0, '0, '0, 1'b1, 32'hAAAA_0001, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 32'hAAAA_0002, 1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_count2 got=%b exp=1", busy_o);
    end
    idle();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_drain got=%b exp=0", busy_o);
    end
  endtask

  task automatic test_no_target_gnt();
    tgt_gnt_i = 1'b0;
    step(1'b1, 17'h00800, 4'h1, 8'h61, 1'b0, '0, 1'b0);
    checks++;
    if (tgt_req_o !== 1'b1 || data_gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL nognt got=%b/%b exp=1/0", tgt_req_o, data_gnt_o);
    end
    idle();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL nognt_busy got=%b exp=0", busy_o);
    end
    tgt_gnt_i = 1'b1;
  endtask

  task automatic test_spurious();
    step(1'b0, '0, '0, '0, 1'b1, 32'h5555_5555, 1'b1);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_early got=%b exp=0", err_o);
    end
    idle();
    checks++;
    if (err_o !== 1'b1 || e_err !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_err got=%b busy=%b exp=1 busy=0", err_o, busy_o);
    end
    step(1'b1, 17'h01000, 4'h2, 8'h71, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 32'hCAFE_0001, 1'b0);
    idle();
    checks++;
    if (err_o !== 1'b1 || data_r_valid_o !== 17'h01000) begin
      errors++;
      $display("FAIL spur_sticky got=%b/%h exp=1/01000", err_o, data_r_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, ID_W'(1) << (i + 4), TAG_W'(i + 4), AUX_W'(8'h80 + i),
                                     1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if ({data_r_valid_o, data_r_rdata_o, data_r_rtag_o, data_r_opc_o, data_r_aux_o} !== '0) begin
      errors++;
      $display("FAIL midrst_resp got=%h/%h/%h/%b/%h exp=0", data_r_valid_o, data_r_rdata_o,
               data_r_rtag_o, data_r_opc_o, data_r_aux_o);
    end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_status got=%b/%b exp=0/0", busy_o, err_o);
    end
    req_q.delete();
    resp_q.delete();
    m_count    = 0;
    m_err      = 1'b0;
    last_id    = '0;
    last_rdata = '0;
    last_tag   = '0;
    last_opc   = 1'b0;
    last_aux   = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b0, '0, '0, '0, 1'b1, 32'h7777_7777, 1'b0);
    idle();
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late got=%b/%b exp=1/0", err_o, busy_o);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_fill();
    test_back_to_back();
    test_simul_push_pop();
    test_no_target_gnt();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
